// File: rtl/program_loader.sv
// program_loader: packs a UART byte stream into big-endian 32-bit words and
// writes them to instruction memory port B from address 0, holding the CPU
// while a program is being loaded.
module program_loader #(
  parameter int B       = 32,
  parameter int N_WORDS = 256
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [B-1:0] o_mem_addr,
  output logic [31:0]  o_mem_data,
  output logic         o_mem_we,
  output logic         o_cpu_hold,
  output logic         o_done,
  output logic         o_overflow,
  output logic [B-1:0] o_word_count
);

  localparam logic [B-1:0] LP_FULL = B'(N_WORDS);
  localparam logic [31:0]  LP_TERM = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t       r_state;
  logic [1:0]   r_byte_idx;
  logic [23:0]  r_asm;
  logic [B-1:0] r_count;
  logic [B-1:0] r_mem_addr;
  logic [31:0]  r_mem_data;
  logic         r_mem_we;
  logic         r_cpu_hold;
  logic         r_done;
  logic         r_overflow;

  state_t       w_state_next;
  logic [1:0]   w_byte_idx_next;
  logic [23:0]  w_asm_next;
  logic [B-1:0] w_count_next;
  logic [B-1:0] w_mem_addr_next;
  logic [31:0]  w_mem_data_next;
  logic         w_mem_we_next;
  logic [31:0]  w_word;

  // The first three bytes sit in r_asm; the fourth completes the word directly.
  assign w_word = {r_asm, i_rx_data};

  // Next-state logic: byte assembly, write issue, terminator and overflow handling.
  always_comb begin
    w_state_next    = r_state;
    w_byte_idx_next = r_byte_idx;
    w_asm_next      = r_asm;
    w_count_next    = r_count;
    w_mem_addr_next = r_mem_addr;
    w_mem_data_next = r_mem_data;
    w_mem_we_next   = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (i_rx_valid) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_asm_next[23:16] = i_rx_data;
            2'd1: w_asm_next[15:8]  = i_rx_data;
            2'd2: w_asm_next[7:0]   = i_rx_data;
            default: begin
              if (r_count == LP_FULL) begin
                w_state_next = S_ERROR;
              end else begin
                w_mem_we_next   = 1'b1;
                w_mem_addr_next = {r_count[B-3:0], 2'b00};
                w_mem_data_next = w_word;
                w_count_next    = r_count + 1'b1;
                if (w_word == LP_TERM) begin
                  w_state_next = S_DONE;
                end
              end
            end
          endcase
        end
      end
      default: begin
        if (i_start) begin
          w_state_next    = S_LOAD;
          w_byte_idx_next = 2'd0;
          w_count_next    = '0;
          w_mem_addr_next = '0;
        end
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they change in the same cycle as the final write strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_byte_idx <= 2'd0;
      r_asm      <= '0;
      r_count    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_byte_idx_next;
      r_asm      <= w_asm_next;
      r_count    <= w_count_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_data <= w_mem_data_next;
      r_mem_we   <= w_mem_we_next;
      r_cpu_hold <= (w_state_next == S_LOAD) || (w_state_next == S_ERROR);
      r_done     <= (w_state_next == S_DONE);
      r_overflow <= (w_state_next == S_ERROR);
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;
  assign o_mem_we     = r_mem_we;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with a 4-word memory.
module tb_program_loader;

  localparam int B  = 32;
  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   rxData = 8'h00;
  logic         rxValid = 1'b0;
  logic [B-1:0] memAddr;
  logic [31:0]  memData;
  logic         memWe;
  logic         cpuHold;
  logic         done;
  logic         overflow;
  logic [B-1:0] wordCount;

  int checkCount = 0;
  int passCount  = 0;
  int weSeen     = 0;
  int expWe      = 0;
  int modelCount = 0;
  logic [63:0] expQ[$];
  logic [63:0] expItem;

  program_loader #(.B(B), .N_WORDS(NW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_mem_addr(memAddr), .o_mem_data(memData), .o_mem_we(memWe),
    .o_cpu_hold(cpuHold), .o_done(done), .o_overflow(overflow),
    .o_word_count(wordCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (memWe === 1'b1) begin
      weSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_we", 32'd1, 32'd0);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("wr_addr", memAddr, expItem[63:32]);
        checkOutput("wr_data", memData, expItem[31:0]);
      end
    end
  end

  // All tasks below start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveByte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    modelCount = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) begin
      if (maxGap > 0) idle($urandom_range(0, maxGap));
      if (i == 3 && modelCount < NW) begin
        expQ.push_back({32'(modelCount * 4), w});
        modelCount++;
        expWe++;
      end
      driveByte(w[31-8*i -: 8]);
    end
  endtask

  initial begin
    // Reset state, and bytes in IDLE are ignored.
    idle(2);
    reset = 1'b1;
    checkOutput("rst_addr", memAddr, 32'd0);
    checkOutput("rst_data", memData, 32'd0);
    checkOutput("rst_flags", {28'd0, memWe, cpuHold, done, overflow}, 32'd0);
    checkOutput("rst_count", wordCount, 32'd0);
    driveByte(8'h12);
    driveByte(8'h34);
    driveByte(8'h56);
    driveByte(8'h78);
    idle(2);
    checkOutput("idle_rx_count", wordCount, 32'd0);

    // Reset in the middle of a load discards the partial word.
    pulseStart();
    checkOutput("start_hold", cpuHold, 32'd1);
    driveByte(8'hDE);
    driveByte(8'hAD);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    checkOutput("midrst_flags", {28'd0, memWe, cpuHold, done, overflow}, 32'd0);
    checkOutput("midrst_count", wordCount, 32'd0);
    pulseStart();
    applyStimulus(32'h1122_3344, 0);
    checkOutput("midrst_count1", wordCount, 32'd1);
    applyStimulus(32'hFFFF_FFFF, 0);

    // Basic load with terminator timing.
    pulseStart();
    checkOutput("basic_done_clr", done, 32'd0);
    checkOutput("basic_count0", wordCount, 32'd0);
    applyStimulus(32'h2001_0005, 0);
    applyStimulus(32'hFFFF_FFFF, 0);
    checkOutput("term_done", done, 32'd1);
    checkOutput("term_hold", cpuHold, 32'd0);
    checkOutput("term_we", memWe, 32'd1);
    checkOutput("term_count", wordCount, 32'd2);

    // Bytes in DONE are ignored.
    driveByte(8'h01);
    driveByte(8'h02);
    driveByte(8'h03);
    driveByte(8'h04);
    idle(1);
    checkOutput("done_rx_count", wordCount, 32'd2);
    checkOutput("done_rx_done", done, 32'd1);

    // Start with a coincident byte, then 12 back-to-back bytes.
    start = 1'b1;
    rxValid = 1'b1;
    rxData = 8'hAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    rxValid = 1'b0;
    modelCount = 0;
    applyStimulus(32'hA1A2_A3A4, 0);
    applyStimulus(32'hB1B2_B3B4, 0);
    applyStimulus(32'hFFFF_FFFF, 0);
    checkOutput("b2b_count", wordCount, 32'd3);
    checkOutput("b2b_done", done, 32'd1);

    // Gapped bytes with a start pulse in the middle of the load.
    pulseStart();
    applyStimulus(32'hA1A2_A3A4, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("midload_start_count", wordCount, 32'd1);
    applyStimulus(32'hB1B2_B3B4, 5);
    applyStimulus(32'hFFFF_FFFF, 5);
    checkOutput("gap_count", wordCount, 32'd3);

    // Overflow: five non-terminator words into a four-word memory.
    pulseStart();
    for (int k = 0; k < 5; k++) applyStimulus(32'h0100_0000 + 32'(k), 0);
    checkOutput("ovf_flag", overflow, 32'd1);
    checkOutput("ovf_hold", cpuHold, 32'd1);
    checkOutput("ovf_we", memWe, 32'd0);
    checkOutput("ovf_count", wordCount, 32'd4);
    driveByte(8'h55);
    idle(1);
    checkOutput("err_rx_count", wordCount, 32'd4);
    pulseStart();
    checkOutput("ovf_clr", overflow, 32'd0);
    checkOutput("ovf_restart_hold", cpuHold, 32'd1);
    checkOutput("ovf_restart_count", wordCount, 32'd0);
    applyStimulus(32'hCAFE_0001, 0);
    applyStimulus(32'hFFFF_FFFF, 0);
    idle(3);

    checkOutput("we_total", 32'(weSeen), 32'(expWe));
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
